mem_writer: RTL and testbench

- Sequential writer for the 10-word x 10-bit lookup memory used by the task datapath.
- Accepts a burst of words over a valid/ready stream and writes them to consecutive addresses from a programmable base.
- Exposes a registered read port so downstream logic can read back the loaded contents.
- Replaces file-initialised contents with contents loaded at run time.

---
 rtl/mem_writer.sv | 151 +++++++++++++++
 tb/tb_mem_writer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_writer.sv
// Burst loader for a small lookup memory with a registered read-back port.
// Optional stored even parity per word is enabled by defining MEM_WRITER_PARITY_EN.
module mem_writer #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
`ifdef MEM_WRITER_PARITY_EN
  ,
  output logic              rd_parity_err
`endif
);

`ifdef MEM_WRITER_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [ADDR_W:0] DEPTH_X = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                mem_we;
  logic [MEM_W-1:0]    mem_wdata;
  logic [MEM_W-1:0]    rd_word;
  logic [ADDR_W:0]     end_sum;

  logic [MEM_W-1:0]    mem [DEPTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    end_sum = {1'b0, base_addr} + {1'b0, length};
    case (state_q)
      IDLE: begin
        if (start) begin
          // Bursts that are empty or run past the last word are rejected whole.
          if ((length == '0) || (end_sum > DEPTH_X)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            ptr_d   = base_addr;
            rem_d   = length;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (wr_valid) begin
          mem_we = 1'b1;
          rem_d  = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) begin
            state_d = DONE;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef MEM_WRITER_PARITY_EN
  assign mem_wdata = {^wr_data, wr_data};
`else
  assign mem_wdata = wr_data;
`endif

  // Storage is deliberately unreset so loaded contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q] <= mem_wdata;
    end
  end

  always_comb begin
    rd_word = '0;
    if ({1'b0, rd_addr} < DEPTH_X) begin
      rd_word = mem[rd_addr];
    end
    rd_data_d = rd_word[DATA_W-1:0];
  end

`ifdef MEM_WRITER_PARITY_EN
  logic rd_perr_q, rd_perr_d;

  // Out-of-range reads yield an all-zero word, whose parity is consistent.
  assign rd_perr_d = ^rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_perr_q <= 1'b0;
    end else begin
      rd_perr_q <= rd_perr_d;
    end
  end

  assign rd_parity_err = rd_perr_q;
`endif

  assign wr_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_mem_writer.sv
// Randomized self-checking bench for mem_writer against an array model of the memory
// and the burst accept/reject rules.
module tb_mem_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] base_addr;
  logic [3:0] length;
  logic       wr_valid;
  logic [9:0] wr_data;
  logic       wr_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] rd_addr;
  logic [9:0] rd_data;
`ifdef MEM_WRITER_PARITY_EN
  logic       rd_parity_err;
`endif

  int total = 0;
  int bad   = 0;

  logic [9:0] model [10];
  bit         model_ok [10];
  logic [9:0] data_q [$];

  mem_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`ifdef MEM_WRITER_PARITY_EN
    ,
    .rd_parity_err(rd_parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    wr_valid = 1'b0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < 10; i++) model_ok[i] = 1'b0;
    #12;
    total++;
    if ({wr_ready, busy, done, err} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_ctrl got=%b want=0000", {wr_ready, busy, done, err});
    end
    total++;
    if (rd_data !== 10'h000) begin
      bad++;
      $display("[TB] FAIL reset_rd_data got=%h want=000", rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // A legal burst must show wr_ready until the last accepted word and pulse done on the next cycle.
  task automatic run_burst(input logic [3:0] base, input logic [3:0] len,
                           input logic [31:0] vmask, input bit rand_valid, input bit spam_start);
    logic [4:0] sum;
    bit         legal;
    int         beats;
    int         cyc;
    sum   = {1'b0, base} + {1'b0, len};
    legal = (len != 4'd0) && (sum <= 5'd10);
    @(negedge clk);
    start = 1'b1; base_addr = base; length = len; wr_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (!legal) begin
      data_q.delete();
      total++;
      if ({busy, wr_ready, done, err} !== 4'b1011) begin
        bad++;
        $display("[TB] FAIL reject_pulse base=%0d len=%0d got=%b want=1011", base, len,
                 {busy, wr_ready, done, err});
      end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, wr_ready, done, err} !== 4'b0001) begin
        bad++;
        $display("[TB] FAIL reject_after base=%0d len=%0d got=%b want=0001", base, len,
                 {busy, wr_ready, done, err});
      end
      return;
    end
    total++;
    if ({busy, wr_ready, done, err} !== 4'b1100) begin
      bad++;
      $display("[TB] FAIL accept_start base=%0d len=%0d got=%b want=1100", base, len,
               {busy, wr_ready, done, err});
    end
    beats = 0;
    cyc   = 0;
    while (beats < int'(len) && cyc < 200) begin
      wr_valid = rand_valid ? 1'($urandom_range(0, 1)) : vmask[cyc % 32];
      if (wr_valid && data_q.size() > 0) wr_data = data_q.pop_front();
      else wr_data = 10'($urandom);
      if (spam_start) begin
        start = 1'b1; base_addr = 4'd9; length = 4'd0;
      end
      @(posedge clk); #1;
      if (wr_valid) begin
        model[int'(base) + beats]    = wr_data;
        model_ok[int'(base) + beats] = 1'b1;
        beats++;
      end
      cyc++;
      start = 1'b0;
      total++;
      if (beats < int'(len)) begin
        if ({busy, wr_ready, done} !== 3'b110) begin
          bad++;
          $display("[TB] FAIL load_cycle cyc=%0d got=%b want=110", cyc, {busy, wr_ready, done});
        end
      end else if ({busy, wr_ready, done} !== 3'b101) begin
        bad++;
        $display("[TB] FAIL done_pulse cyc=%0d got=%b want=101", cyc, {busy, wr_ready, done});
      end
    end
    if (beats < int'(len)) begin
      total++;
      bad++;
      $display("[TB] FAIL burst_timeout beats=%0d want=%0d", beats, len);
    end
    wr_valid = 1'b0;
    data_q.delete();
    @(posedge clk); #1;
    total++;
    if ({busy, wr_ready, done, err} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL burst_idle got=%b want=0000", {busy, wr_ready, done, err});
    end
  endtask

  task automatic test_readback();
    logic [9:0] exp;
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rd_addr = 4'(a);
      @(posedge clk); #1;
      if (a >= 10 || model_ok[a]) begin
        exp = (a >= 10) ? 10'h000 : model[a];
        total++;
        if (rd_data !== exp) begin
          bad++;
          $display("[TB] FAIL readback addr=%0d got=%h want=%h", a, rd_data, exp);
        end
`ifdef MEM_WRITER_PARITY_EN
        total++;
        if (rd_parity_err !== 1'b0) begin
          bad++;
          $display("[TB] FAIL parity addr=%0d got=%b want=0", a, rd_parity_err);
        end
`endif
      end
    end
  endtask

  task automatic test_full_burst();
    for (int i = 0; i < 10; i++) data_q.push_back(10'(i));
    run_burst(4'd0, 4'd10, 32'hFFFF_FFFF, 1'b0, 1'b0);
    test_readback();
  endtask

  task automatic test_range_error();
    run_burst(4'd7, 4'd4, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_burst(4'd3, 4'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    test_readback();
    run_burst(4'd7, 4'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
  endtask

  task automatic test_valid_gaps();
    data_q.push_back(10'h3FF);
    data_q.push_back(10'h155);
    data_q.push_back(10'h2AA);
    run_burst(4'd2, 4'd3, 32'b10_1001, 1'b0, 1'b0);
    test_readback();
  endtask

  task automatic test_start_ignored();
    run_burst(4'd0, 4'd3, 32'hFFFF_FFFF, 1'b0, 1'b1);
  endtask

  task automatic test_read_before_write();
    logic [9:0] old;
    old = model[5];
    @(negedge clk);
    start = 1'b1; base_addr = 4'd5; length = 4'd1;
    @(posedge clk); #1;
    start = 1'b0; wr_valid = 1'b1; wr_data = 10'h123; rd_addr = 4'd5;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    model[5] = 10'h123;
    total++;
    if (rd_data !== old) begin
      bad++;
      $display("[TB] FAIL rbw_old got=%h want=%h", rd_data, old);
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rbw_done got=%b want=1", done);
    end
    @(posedge clk); #1;
    rd_addr = 4'd12;
    total++;
    if (rd_data !== 10'h123) begin
      bad++;
      $display("[TB] FAIL rbw_new got=%h want=123", rd_data);
    end
    @(posedge clk); #1;
    total++;
    if (rd_data !== 10'h000) begin
      bad++;
      $display("[TB] FAIL rd_out_of_range got=%h want=000", rd_data);
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic [3:0] l;
    for (int n = 0; n < 8; n++) begin
      b = 4'($urandom_range(0, 9));
      l = 4'($urandom_range(0, 11 - int'(b)));
      run_burst(b, l, 32'h0, 1'b1, 1'b0);
    end
    test_readback();
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    start = 1'b1; base_addr = 4'd0; length = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = 10'($urandom);
      @(posedge clk); #1;
      model[i]    = wr_data;
      model_ok[i] = 1'b1;
    end
    wr_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, wr_ready, done, err} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL async_reset got=%b want=0000", {busy, wr_ready, done, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL post_reset got=%b want=00", {busy, done});
    end
    test_readback();
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_range_error();
    test_valid_gaps();
    test_start_ignored();
    test_read_before_write();
    test_random();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
